uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame controller behind the UART receiver. Consumes its byte stream (1-cycle
//  data_valid pulse + 8-bit parallel_data), parses SYNC/ADDR/LEN/payload/CHK
//  frames, buffers the payload, and writes it to a register bus only after the
//  checksum passes. Reports frame completion and errors to the host logic.
// PARAMETERS
//  MAX_LEN       16     max payload bytes per frame; buffer depth
//  TIMEOUT_CLKS  20800  inter-byte timeout in clk cycles (4 byte times @ 520 clk/bit)
//  SYNC_BYTE     8'hA5  frame start marker
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  rx_valid    in   1  byte strobe from receiver data_valid (1-cycle pulse)
//  rx_data     in   8  byte from receiver parallel_data
//  wr_valid    out  1  register write request
//  wr_ready    in   1  register bus accepts write (handshake = wr_valid & wr_ready)
//  wr_addr     out  8  write address
//  wr_data     out  8  write data
//  frame_done  out  1  1-cycle pulse: frame fully committed
//  frame_err   out  1  1-cycle pulse: frame/byte rejected
//  err_code    out  2  valid with frame_err: 0 CHK, 1 LEN, 2 TIMEOUT, 3 OVERRUN
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset (any state, incl.
//    mid-frame/mid-commit) -> IDLE; wr_valid, frame_done, frame_err, busy = 0;
//    wr_addr, wr_data, err_code = 0; timer, index, checksum cleared. Buffer not cleared.
//  - FSM: IDLE -> ADDR -> LEN -> PAYLOAD -> CHK -> COMMIT -> IDLE.
//    IDLE: rx_valid & rx_data==SYNC_BYTE -> ADDR; any other byte is ignored silently.
//    ADDR: store base address; chk = rx_data. -> LEN.
//    LEN: chk ^= byte. byte > MAX_LEN -> frame_err(LEN), IDLE. byte == 0 -> CHK,
//         else -> PAYLOAD with index = 0.
//    PAYLOAD: buf[index] = byte, chk ^= byte, index++; after LEN bytes -> CHK.
//    CHK: byte == chk -> COMMIT (LEN>0) or frame_done pulse next cycle and IDLE
//         (LEN==0); mismatch -> frame_err(CHK), IDLE.
//    COMMIT: wr_valid asserted the cycle after CHK accept; wr_addr = base+i (mod 256,
//         wraps 8'hFF->8'h00), wr_data = buf[i]; wr_valid/addr/data held stable
//         until handshake; i advances only on handshake. Cycle after final
//         handshake: wr_valid=0, frame_done=1, -> IDLE.
//  - Checksum: 8-bit XOR of ADDR, LEN and all payload bytes (SYNC excluded).
//  - Timeout: in ADDR/LEN/PAYLOAD/CHK timer counts clk cycles since last accepted
//    byte; reaching TIMEOUT_CLKS -> frame_err(TIMEOUT), IDLE. rx_valid in the same
//    cycle as expiry wins: byte accepted, timer reloads. No timeout in IDLE/COMMIT.
//  - Receiver has no backpressure: rx_valid during COMMIT drops the byte and pulses
//    frame_err(OVERRUN); commit continues unaffected. A SYNC byte dropped this way
//    is not re-detected.
//  - frame_err and frame_done never assert in the same cycle; at most one pulse/cycle.
//  - All outputs registered; widths: index/count $clog2(MAX_LEN+1), timer $clog2(TIMEOUT_CLKS+1).
// STRUCTURE
//  - Shared package uart_pkg: SYNC_BYTE default, FSM state encodings, err_code
//    constants (ERR_CHK, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN).
//  - One sub-module: uart_frame_buf (MAX_LEN x 8 register array, 1 write port
//    indexed by PAYLOAD count, 1 async read port indexed by commit pointer).
//  - Timer, checksum and FSM stay in this module.
// TESTING
//  1 Frame A5 10 02 11 22 CHK=10^02^11^22=21, wr_ready=1 -> writes (10,11),(11,22)
//    on consecutive cycles, frame_done 1 cycle later, no frame_err.
//  2 Same frame with CHK=20 -> frame_err, err_code=0, no wr_valid, busy drops next cycle.
//  3 A5 FE 03 01 02 03 CHK, wr_ready toggling 1010.. -> addrs FE,FF,00 (wrap),
//    addr/data stable while wr_ready=0, exactly 3 handshakes.
//  4 A5 00 11 (LEN=17 > MAX_LEN) -> frame_err, err_code=1; following valid frame
//    accepted normally. LEN=0 frame A5 05 00 05 -> frame_done, no writes.
//  5 A5 10 then silence TIMEOUT_CLKS cycles -> frame_err, err_code=2; byte arriving
//    exactly on expiry cycle -> accepted, no error.
//  6 rx_valid during COMMIT with wr_ready=0 -> frame_err err_code=3, commit completes;
//    rst asserted mid-PAYLOAD -> all outputs 0, busy=0, next frame parses cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_CHK     = 2'd0;
    localparam err_code_t ERR_LEN     = 2'd1;
    localparam err_code_t ERR_TIMEOUT = 2'd2;
    localparam err_code_t ERR_OVERRUN = 2'd3;

    // One register-bus write beat.
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte stream in, register-write bus and status out.
interface uart_rx_frame_ctrl_if;
    import uart_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    err_code_t  err_code;
    logic       busy;

    // Controller side.
    modport master (
        input  rx_valid, rx_data, wr_ready,
        output wr_valid, wr_addr, wr_data, frame_done, frame_err, err_code, busy
    );

    // Receiver / register bus / host side.
    modport slave (
        output rx_valid, rx_data, wr_ready,
        input  wr_valid, wr_addr, wr_data, frame_done, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: one synchronous write port, one asynchronous read port.
module uart_frame_buf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata_c
);

    logic [7:0] mem [DEPTH];

    // Store payload bytes; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames and commits payload to the register bus.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 20800,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_frame_ctrl_if.master bus
);

    localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cptr_q, cptr_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic [7:0]         base_q, base_d;
    logic [7:0]         chk_q, chk_d;
    logic               pend_ovr_q, pend_ovr_d;
    logic               wr_valid_q, wr_valid_d;
    wr_req_t            wr_req_q, wr_req_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_err_q, frame_err_d;
    err_code_t          err_code_q, err_code_d;
    logic               busy_q, busy_d;

    logic               timed_c;
    logic               tmo_c;
    logic               hs_c;
    logic               buf_we_c;
    logic [BUF_AW-1:0]  buf_raddr_c;
    logic [7:0]         buf_rdata_c;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we_c),
        .waddr   (BUF_AW'(idx_q)),
        .wdata   (bus.rx_data),
        .raddr   (buf_raddr_c),
        .rdata_c (buf_rdata_c)
    );

    assign timed_c = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign tmo_c   = timed_c && !bus.rx_valid && (timer_q == TMR_LAST);
    assign hs_c    = wr_valid_q && bus.wr_ready;

    // Read the entry the next write beat will carry (entry 0 when entering commit).
    assign buf_raddr_c = (state_q == ST_COMMIT) ? BUF_AW'(cptr_q + IDX_W'(1)) : '0;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        idx_d        = idx_q;
        cptr_d       = cptr_q;
        len_d        = len_q;
        base_d       = base_q;
        chk_d        = chk_q;
        pend_ovr_d   = pend_ovr_q;
        wr_valid_d   = wr_valid_q;
        wr_req_d     = wr_req_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        buf_we_c     = 1'b0;

        if (timed_c && !bus.rx_valid) begin
            timer_d = timer_q + TMR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Overrun that collided with the final commit beat is reported now.
                if (pend_ovr_q) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                    pend_ovr_d  = 1'b0;
                end
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (bus.rx_valid) begin
                    base_d  = bus.rx_data;
                    chk_d   = bus.rx_data;
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (bus.rx_valid) begin
                    chk_d = chk_q ^ bus.rx_data;
                    if (bus.rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d   = IDX_W'(bus.rx_data);
                        idx_d   = '0;
                        state_d = (bus.rx_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (bus.rx_valid) begin
                    buf_we_c = 1'b1;
                    chk_d    = chk_q ^ bus.rx_data;
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_d == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end

            ST_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data != chk_q) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = ST_IDLE;
                    end else if (len_q == '0) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cptr_d        = '0;
                        wr_valid_d    = 1'b1;
                        wr_req_d.addr = base_q;
                        wr_req_d.data = buf_rdata_c;
                        state_d       = ST_COMMIT;
                    end
                end
            end

            ST_COMMIT: begin
                if (hs_c) begin
                    if (cptr_q == (len_q - IDX_W'(1))) begin
                        wr_valid_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cptr_d        = cptr_q + IDX_W'(1);
                        wr_req_d.addr = base_q + 8'(cptr_d);
                        wr_req_d.data = buf_rdata_c;
                    end
                end
                // No backpressure to the receiver: the byte is lost.
                if (bus.rx_valid) begin
                    if (frame_done_d) begin
                        pend_ovr_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVERRUN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Expiry only fires when no byte arrived this cycle.
        if (tmo_c) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
            timer_d     = '0;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            cptr_q       <= '0;
            len_q        <= '0;
            base_q       <= '0;
            chk_q        <= '0;
            pend_ovr_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_req_q     <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_CHK;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            cptr_q       <= cptr_d;
            len_q        <= len_d;
            base_q       <= base_d;
            chk_q        <= chk_d;
            pend_ovr_q   <= pend_ovr_d;
            wr_valid_q   <= wr_valid_d;
            wr_req_q     <= wr_req_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_addr    = wr_req_q.addr;
    assign bus.wr_data    = wr_req_q.data;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = busy_q;

endmodule
